cnn_core_seq_ctrl: RTL and testbench

//  Layer sequencer for one cnn_core instance. Per frame: clears the core, admits exactly
//  OW*OH im2col windows from the window source, and tracks windows in flight.

---
 rtl/cnn_core_seq_ctrl_pkg.sv | 33 +++
 rtl/cnn_core_seq_ctrl_credit_cnt.sv | 40 ++++
 rtl/cnn_core_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_cnn_core_seq_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_core_seq_ctrl_pkg.sv
// Shared state encoding and geometry helpers for the cnn_core
// layer sequencer and its credit counter.
package cnn_core_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_DRAIN,
      ST_DONE,
      ST_ABORT
   } state_e;

   localparam int unsigned DEF_FMAP_W  = 6;
   localparam int unsigned DEF_FMAP_H  = 6;
   localparam int unsigned DEF_KX      = 3;
   localparam int unsigned DEF_KY      = 3;
   localparam int unsigned DEF_CREDITS = 4;

   function automatic int unsigned out_dim(
      input int unsigned fmap,
      input int unsigned k
   );
      return fmap - k + 1;
   endfunction

   function automatic int unsigned cnt_bits(
      input int unsigned n
   );
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/cnn_core_seq_ctrl_credit_cnt.sv
// Up/down credit counter: starts full, returns above full are
// dropped and flagged.
module cnn_core_seq_ctrl_credit_cnt
   import cnn_core_seq_ctrl_pkg::*;
#(
   parameter  int unsigned CREDITS = DEF_CREDITS,
   localparam int unsigned CR_BW   = cnt_bits(CREDITS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CR_BW-1:0] o_count,
   output logic             o_ovf
);

   localparam logic [CR_BW-1:0] MAX = CR_BW'(CREDITS);

   logic [CR_BW-1:0] cnt_q, cnt_d;
   logic             full;

   assign full    = (cnt_q == MAX);
   assign o_count = cnt_q;
   assign o_ovf   = i_inc & ~i_dec & full;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({i_inc, i_dec})
         2'b10:   if (!full) cnt_d = cnt_q + CR_BW'(1);
         2'b01:   cnt_d = cnt_q - CR_BW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= MAX;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/cnn_core_seq_ctrl.sv
// Layer sequencer for one cnn_core: clears the core, issues OW*OH
// windows under result-buffer credit, tags results with (x,y).
module cnn_core_seq_ctrl
   import cnn_core_seq_ctrl_pkg::*;
#(
   parameter  int unsigned FMAP_W  = DEF_FMAP_W,
   parameter  int unsigned FMAP_H  = DEF_FMAP_H,
   parameter  int unsigned KX      = DEF_KX,
   parameter  int unsigned KY      = DEF_KY,
   parameter  int unsigned CREDITS = DEF_CREDITS,
   localparam int unsigned CNT_BW  =
      cnt_bits(out_dim(FMAP_W, KX) * out_dim(FMAP_H, KY))
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic              i_win_valid,
   output logic              o_win_ready,
   output logic              o_core_valid,
   output logic              o_core_soft_reset,
   input  logic              i_core_valid,
   input  logic              i_credit_ret,
   output logic              o_res_push,
   output logic [CNT_BW-1:0] o_res_x,
   output logic [CNT_BW-1:0] o_res_y,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   localparam int unsigned OW    = out_dim(FMAP_W, KX);
   localparam int unsigned OH    = out_dim(FMAP_H, KY);
   localparam int unsigned NWIN  = OW * OH;
   localparam int unsigned CR_BW = cnt_bits(CREDITS);

   localparam logic [CNT_BW-1:0] NWIN_C = CNT_BW'(NWIN);
   localparam logic [CNT_BW-1:0] X_LAST = CNT_BW'(OW - 1);
   localparam logic [CNT_BW-1:0] Y_LAST = CNT_BW'(OH - 1);

   state_e            state_q, state_d;
   logic [CNT_BW-1:0] issued_q, issued_d;
   logic [CNT_BW-1:0] received_q, received_d;
   logic [CNT_BW-1:0] x_q, x_d;
   logic [CNT_BW-1:0] y_q, y_d;
   logic              err_q, err_d;

   logic [CR_BW-1:0]  credits;
   logic              cr_ovf;
   logic              fire;
   logic              push;
   logic              spur;
   logic              start_ok;
   logic              abort_ok;
   logic              collecting;

   assign start_ok   = i_start & ~i_abort & (state_q == ST_IDLE);
   assign abort_ok   = i_abort & (state_q != ST_IDLE);
   assign collecting = (state_q == ST_RUN) | (state_q == ST_DRAIN);

   assign o_win_ready = (state_q == ST_RUN) & (issued_q != NWIN_C)
                      & (credits != '0);
   assign fire        = i_win_valid & o_win_ready;
   assign push        = i_core_valid & collecting
                      & (received_q != issued_q);
   // The core is being flushed during ABORT, so its output is ignored.
   assign spur        = i_core_valid & ~push & (state_q != ST_ABORT);

   cnn_core_seq_ctrl_credit_cnt #(
      .CREDITS (CREDITS)
   ) u_credit (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (i_credit_ret),
      .i_dec   (fire),
      .o_count (credits),
      .o_ovf   (cr_ovf)
   );

   always_comb begin
      state_d    = state_q;
      issued_d   = issued_q;
      received_d = received_q;
      x_d        = x_q;
      y_d        = y_q;
      err_d      = err_q;

      unique case (state_q)
         ST_IDLE:  if (start_ok) state_d = ST_CLEAR;
         ST_CLEAR: state_d = ST_RUN;
         ST_RUN:   if (issued_q == NWIN_C) state_d = ST_DRAIN;
         ST_DRAIN: if (received_q == NWIN_C) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         ST_ABORT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (fire) issued_d = issued_q + CNT_BW'(1);

      if (push) begin
         received_d = received_q + CNT_BW'(1);
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + CNT_BW'(1);
         end else begin
            x_d = x_q + CNT_BW'(1);
         end
      end

      if (start_ok || abort_ok) begin
         issued_d   = '0;
         received_d = '0;
         x_d        = '0;
         y_d        = '0;
      end

      if (abort_ok) state_d = ST_ABORT;

      if (start_ok)      err_d = 1'b0;
      if (spur || cr_ovf) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         issued_q   <= '0;
         received_q <= '0;
         x_q        <= '0;
         y_q        <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         issued_q   <= issued_d;
         received_q <= received_d;
         x_q        <= x_d;
         y_q        <= y_d;
         err_q      <= err_d;
      end
   end

   assign o_core_valid      = fire;
   assign o_core_soft_reset = (state_q == ST_CLEAR) | (state_q == ST_ABORT);
   assign o_res_push        = push;
   assign o_res_x           = x_q;
   assign o_res_y           = y_q;
   assign o_busy            = (state_q != ST_IDLE);
   assign o_done            = (state_q == ST_DONE);
   assign o_err             = err_q;

endmodule

// File: tb/tb_cnn_core_seq_ctrl.sv
// Directed bench for cnn_core_seq_ctrl with a fixed 3-cycle core
// model and a result-buffer sink that pops automatically or on demand.
module tb_cnn_core_seq_ctrl;

   localparam int CNT_BW = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              start, abort, win_valid, win_ready;
   logic              core_valid, soft_reset, core_in_valid;
   logic              credit_ret, res_push, busy, done, err;
   logic [CNT_BW-1:0] res_x, res_y;
   logic              auto_pop, pop_inj, spur_inj;
   logic [2:0]        pipe;

   int total = 0;
   int bad   = 0;
   int n_cv  = 0;
   int n_push = 0;
   int n_done = 0;
   int qx[$];
   int qy[$];

   always #5 clk = ~clk;

   cnn_core_seq_ctrl dut (
      .clk               (clk),
      .reset             (rst),
      .i_start           (start),
      .i_abort           (abort),
      .i_win_valid       (win_valid),
      .o_win_ready       (win_ready),
      .o_core_valid      (core_valid),
      .o_core_soft_reset (soft_reset),
      .i_core_valid      (core_in_valid),
      .i_credit_ret      (credit_ret),
      .o_res_push        (res_push),
      .o_res_x           (res_x),
      .o_res_y           (res_y),
      .o_busy            (busy),
      .o_done            (done),
      .o_err             (err)
   );

   assign core_in_valid = pipe[2] | spur_inj;
   assign credit_ret    = auto_pop ? res_push : pop_inj;

   always @(posedge clk or posedge rst) begin
      if (rst)             pipe <= '0;
      else if (soft_reset) pipe <= '0;
      else                 pipe <= {pipe[1:0], core_valid};
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (core_valid) n_cv++;
         if (done) n_done++;
         if (res_push) begin
            n_push++;
            qx.push_back(int'(res_x));
            qy.push_back(int'(res_y));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0; abort = 1'b0; win_valid = 1'b0;
      auto_pop = 1'b0; pop_inj = 1'b0; spur_inj = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic wait_idle(input string tag, input int max);
      int k;
      k = 0;
      while (busy && k < max) begin
         step();
         k++;
      end
      chk(tag, int'(busy), 0);
   endtask

   initial begin
      int b_cv, b_push, b_done, b_q, k;

      // reset state
      rst = 1'b1;
      start = 1'b0; abort = 1'b0; win_valid = 1'b0;
      auto_pop = 1'b0; pop_inj = 1'b0; spur_inj = 1'b0;
      step();
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(win_ready), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_soft", int'(soft_reset), 0);
      chk("rst_push", int'(res_push), 0);
      rst = 1'b0;
      step();

      // 1 nominal frame
      do_reset();
      b_cv = n_cv; b_push = n_push; b_done = n_done; b_q = qx.size();
      auto_pop = 1'b1;
      win_valid = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t1_clear_soft", int'(soft_reset), 1);
      chk("t1_busy", int'(busy), 1);
      wait_idle("t1_timeout", 200);
      win_valid = 1'b0;
      chk("t1_cv", n_cv - b_cv, 16);
      chk("t1_push", n_push - b_push, 16);
      chk("t1_done", n_done - b_done, 1);
      chk("t1_err", int'(err), 0);
      for (int i = 0; i < 16; i++) begin
         if (b_q + i < qx.size()) begin
            chk($sformatf("t1_x%0d", i), qx[b_q + i], i % 4);
            chk($sformatf("t1_y%0d", i), qy[b_q + i], i / 4);
         end
      end

      // 2 backpressure
      do_reset();
      b_cv = n_cv; b_push = n_push;
      win_valid = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (20) step();
      chk("t2_cv4", n_cv - b_cv, 4);
      chk("t2_push4", n_push - b_push, 4);
      chk("t2_ready", int'(win_ready), 0);
      chk("t2_busy", int'(busy), 1);
      pop_inj = 1'b1;
      step();
      pop_inj = 1'b0;
      repeat (6) step();
      chk("t2_cv5", n_cv - b_cv, 5);
      chk("t2_ready2", int'(win_ready), 0);
      win_valid = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t2_abort_soft", int'(soft_reset), 1);
      chk("t2_abort_busy", int'(busy), 1);
      step();
      chk("t2_idle", int'(busy), 0);
      chk("t2_soft_off", int'(soft_reset), 0);

      // 3 fire and credit return together at credits=1
      do_reset();
      b_cv = n_cv;
      win_valid = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (n_cv - b_cv < 3 && k < 20) begin
         step();
         k++;
      end
      chk("t3_three", n_cv - b_cv, 3);
      pop_inj = 1'b1;
      #1;
      chk("t3_ready", int'(win_ready), 1);
      chk("t3_fire", int'(core_valid), 1);
      step();
      pop_inj = 1'b0;
      win_valid = 1'b0;
      #1;
      chk("t3_ready_next", int'(win_ready), 1);
      win_valid = 1'b1;
      step();
      chk("t3_ready_zero", int'(win_ready), 0);
      chk("t3_cv5", n_cv - b_cv, 5);

      // 4 abort after 7 issues, then a full frame
      do_reset();
      b_cv = n_cv; b_done = n_done;
      auto_pop = 1'b1;
      win_valid = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (n_cv - b_cv < 7 && k < 100) begin
         step();
         k++;
      end
      win_valid = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t4_soft", int'(soft_reset), 1);
      step();
      chk("t4_idle", int'(busy), 0);
      chk("t4_soft_off", int'(soft_reset), 0);
      repeat (4) step();
      chk("t4_cv7", n_cv - b_cv, 7);
      chk("t4_no_done", n_done - b_done, 0);
      chk("t4_err", int'(err), 0);
      b_cv = n_cv; b_push = n_push; b_done = n_done; b_q = qx.size();
      win_valid = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_idle("t4_timeout", 400);
      win_valid = 1'b0;
      chk("t4r_cv", n_cv - b_cv, 16);
      chk("t4r_push", n_push - b_push, 16);
      chk("t4r_done", n_done - b_done, 1);
      chk("t4r_err", int'(err), 0);
      if (qx.size() >= b_q + 16) begin
         chk("t4r_x0", qx[b_q], 0);
         chk("t4r_y0", qy[b_q], 0);
         chk("t4r_x5", qx[b_q + 5], 1);
         chk("t4r_y5", qy[b_q + 5], 1);
         chk("t4r_x15", qx[b_q + 15], 3);
         chk("t4r_y15", qy[b_q + 15], 3);
      end

      // 5 spurious core valid in IDLE, start clears the error
      do_reset();
      b_push = n_push;
      spur_inj = 1'b1;
      #1;
      chk("t5_no_push", int'(res_push), 0);
      step();
      spur_inj = 1'b0;
      chk("t5_err", int'(err), 1);
      chk("t5_idle", int'(busy), 0);
      chk("t5_push_cnt", n_push - b_push, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t5_err_clr", int'(err), 0);
      chk("t5_clear", int'(soft_reset), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();
      chk("t5_back_idle", int'(busy), 0);

      // credit return while already full
      do_reset();
      pop_inj = 1'b1;
      step();
      pop_inj = 1'b0;
      chk("t5_ovf_err", int'(err), 1);

      // start and abort together in IDLE
      do_reset();
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk("t5_sa_busy", int'(busy), 0);
      chk("t5_sa_soft", int'(soft_reset), 0);

      // 6 reset during DRAIN
      do_reset();
      b_cv = n_cv;
      auto_pop = 1'b1;
      win_valid = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (n_cv - b_cv < 16 && k < 200) begin
         step();
         k++;
      end
      chk("t6_cv16", n_cv - b_cv, 16);
      step();
      chk("t6_drain_busy", int'(busy), 1);
      chk("t6_drain_done", int'(done), 0);
      rst = 1'b1;
      #1;
      chk("t6_busy", int'(busy), 0);
      chk("t6_ready", int'(win_ready), 0);
      chk("t6_cvalid", int'(core_valid), 0);
      chk("t6_push", int'(res_push), 0);
      chk("t6_x", int'(res_x), 0);
      chk("t6_y", int'(res_y), 0);
      chk("t6_done", int'(done), 0);
      chk("t6_err", int'(err), 0);
      chk("t6_soft", int'(soft_reset), 0);
      win_valid = 1'b0;
      auto_pop = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      b_cv = n_cv;
      win_valid = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (20) step();
      chk("t6_credits4", n_cv - b_cv, 4);
      win_valid = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
